// File: rtl/execute_stage.sv
// Execute stage of the RV32I pipeline: ID/EX register, forwarding, ALU, branch resolve, EX/MEM register.
// Latency: 2 cycles from decode bundle to M outputs (ID/EX edge, then EX/MEM edge).
// Backpressure: StallE holds ID/EX and FlushE (priority) bubbles it; EX/MEM captures every edge.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   StallE, FlushE             hazard-unit hold / bubble for the ID/EX register
//   *D inputs                  decode-stage control and operands captured into ID/EX
//   ForwardAE/BE, ResultW      operand forwarding selects and writeback-stage value
//   Rs1E, Rs2E, RdE,
//   ResultSrcE0                ID/EX fields exposed to the hazard unit
//   PCSrcE, PCTargetE          fetch redirect, combinational from ID/EX state
//   *M outputs                 EX/MEM register contents for the memory stage
module execute_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [2:0]      ALUControlD,
  input  logic            ALUSrcD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic [1:0]      ResultSrcD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic [REGW-1:0] RdD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic [REGW-1:0] Rs1E,
  output logic [REGW-1:0] Rs2E,
  output logic [REGW-1:0] RdE,
  output logic            ResultSrcE0,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [REGW-1:0] RdM
);

  // ALU operation encodings from the ALU control decoder.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Forwarding select encodings; 2'b11 falls back to the register value.
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
    logic [REGW-1:0] rd;
  } exmem_t;

  idex_t           r_idex;
  exmem_t          r_exmem;
  idex_t           w_idex_d;
  exmem_t          w_exmem_d;
  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_slt;
  logic            w_zero;

  // Decode bundle as it will be captured into ID/EX.
  always_comb begin
    w_idex_d            = '0;
    w_idex_d.reg_write  = RegWriteD;
    w_idex_d.mem_write  = MemWriteD;
    w_idex_d.branch     = BranchD;
    w_idex_d.jump       = JumpD;
    w_idex_d.alu_src    = ALUSrcD;
    w_idex_d.result_src = ResultSrcD;
    w_idex_d.alu_ctrl   = ALUControlD;
    w_idex_d.rd1        = RD1D;
    w_idex_d.rd2        = RD2D;
    w_idex_d.imm        = ImmExtD;
    w_idex_d.pc         = PCD;
    w_idex_d.pc_plus4   = PCPlus4D;
    w_idex_d.rs1        = Rs1D;
    w_idex_d.rs2        = Rs2D;
    w_idex_d.rd         = RdD;
  end

  // ID/EX register. A flush beats a stall so the hazard unit can bubble a
  // stalled slot; an all-zero bubble is ADD 0+0 with no writes, i.e. a no-op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex <= '0;
    end else if (FlushE) begin
      r_idex <= '0;
    end else if (!StallE) begin
      r_idex <= w_idex_d;
    end
  end

  // Operand forwarding. The M-stage source is this block's own EX/MEM output.
  always_comb begin
    case (ForwardAE)
      FWD_W:   w_src_a = ResultW;
      FWD_M:   w_src_a = r_exmem.alu_result;
      default: w_src_a = r_idex.rd1;
    endcase
  end

  always_comb begin
    case (ForwardBE)
      FWD_W:   w_fwd_b = ResultW;
      FWD_M:   w_fwd_b = r_exmem.alu_result;
      default: w_fwd_b = r_idex.rd2;
    endcase
  end

  // The store data is always the forwarded register value, never the immediate.
  assign w_src_b = r_idex.alu_src ? r_idex.imm : w_fwd_b;

  assign w_slt = ($signed(w_src_a) < $signed(w_src_b));

  always_comb begin
    case (r_idex.alu_ctrl)
      ALU_ADD: w_alu_result = w_src_a + w_src_b;
      ALU_SUB: w_alu_result = w_src_a - w_src_b;
      ALU_AND: w_alu_result = w_src_a & w_src_b;
      ALU_OR:  w_alu_result = w_src_a | w_src_b;
      ALU_SLT: w_alu_result = {{(XLEN-1){1'b0}}, w_slt};
      default: w_alu_result = '0;
    endcase
  end

  assign w_zero = (w_alu_result == '0);

  // Branch/jump resolution; branches compare with SUB so Zero means equal.
  assign PCTargetE = r_idex.pc + r_idex.imm;
  assign PCSrcE    = (r_idex.branch & w_zero) | r_idex.jump;

  always_comb begin
    w_exmem_d            = '0;
    w_exmem_d.reg_write  = r_idex.reg_write;
    w_exmem_d.mem_write  = r_idex.mem_write;
    w_exmem_d.result_src = r_idex.result_src;
    w_exmem_d.alu_result = w_alu_result;
    w_exmem_d.write_data = w_fwd_b;
    w_exmem_d.pc_plus4   = r_idex.pc_plus4;
    w_exmem_d.rd         = r_idex.rd;
  end

  // EX/MEM register: no hold or bubble of its own; a stalled EX slot simply
  // re-issues the same result, which the downstream stages tolerate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exmem <= '0;
    end else begin
      r_exmem <= w_exmem_d;
    end
  end

  assign Rs1E        = r_idex.rs1;
  assign Rs2E        = r_idex.rs2;
  assign RdE         = r_idex.rd;
  assign ResultSrcE0 = r_idex.result_src[0];

  assign RegWriteM   = r_exmem.reg_write;
  assign MemWriteM   = r_exmem.mem_write;
  assign ResultSrcM  = r_exmem.result_src;
  assign ALUResultM  = r_exmem.alu_result;
  assign WriteDataM  = r_exmem.write_data;
  assign PCPlus4M    = r_exmem.pc_plus4;
  assign RdM         = r_exmem.rd;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic        StallE;
  logic        FlushE;
  logic [2:0]  ALUControlD;
  logic        ALUSrcD;
  logic        RegWriteD;
  logic        MemWriteD;
  logic        BranchD;
  logic        JumpD;
  logic [1:0]  ResultSrcD;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ImmExtD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  RdD;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic        ResultSrcE0;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RdM;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pcp4;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
  } exp_t;

  exp_t sb[$];

  execute_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
    .ResultSrcD(ResultSrcD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    ALUControlD = 3'b000; ALUSrcD = 1'b0; RegWriteD = 1'b0; MemWriteD = 1'b0;
    BranchD = 1'b0; JumpD = 1'b0; ResultSrcD = 2'b00;
    RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0; PCPlus4D = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0;
  endtask

  task automatic push(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                      input logic [31:0] pcp4, input logic [4:0] rd, input logic rw,
                      input logic mw, input logic [1:0] rs);
    exp_t e;
    e.tag = tag; e.alu = alu; e.wd = wd; e.pcp4 = pcp4;
    e.rd = rd; e.rw = rw; e.mw = mw; e.rs = rs;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the EX/MEM outputs.
  task automatic check_m();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".alu"},  ALUResultM, e.alu);
      chk({e.tag, ".wd"},   WriteDataM, e.wd);
      chk({e.tag, ".pcp4"}, PCPlus4M, e.pcp4);
      chk({e.tag, ".rd"},   {27'd0, RdM}, {27'd0, e.rd});
      chk({e.tag, ".rw"},   {31'd0, RegWriteM}, {31'd0, e.rw});
      chk({e.tag, ".mw"},   {31'd0, MemWriteM}, {31'd0, e.mw});
      chk({e.tag, ".rs"},   {30'd0, ResultSrcM}, {30'd0, e.rs});
    end
  endtask

  logic [2:0]  alu_codes [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b100, 3'b111};
  logic [31:0] alu_exps  [8] = '{32'h80000001, 32'h7FFFFFFF, 32'h0, 32'h80000001,
                                 32'h1, 32'h0, 32'h0, 32'h0};

  initial begin
    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = '0;
    set_nop();
    tick(); tick();
    chk("rst.alu_m", ALUResultM, 32'h0);
    chk("rst.pcsrc", {31'd0, PCSrcE}, 32'h0);
    chk("rst.rde",   {27'd0, RdE}, 32'h0);
    chk("rst.rw_m",  {31'd0, RegWriteM}, 32'h0);
    #3 rst_n = 1'b1;

    // ADD 5+7 after reset release
    RD1D = 32'd5; RD2D = 32'd7; RegWriteD = 1'b1; RdD = 5'd3; PCPlus4D = 32'd4;
    push("add", 32'd12, 32'd7, 32'd4, 5'd3, 1'b1, 1'b0, 2'b00);
    tick();
    set_nop();
    chk("add.rde", {27'd0, RdE}, 32'd3);
    tick();
    check_m();

    // Every ALU code, back to back, with A=0x80000000 and B=1
    for (int i = 0; i < 8; i++) begin
      set_nop();
      ALUControlD = alu_codes[i]; RD1D = 32'h80000000; RD2D = 32'h1;
      RegWriteD = 1'b1; RdD = 5'(i + 1); PCPlus4D = 32'h1000 + 32'(4 * i);
      push($sformatf("alu%0d", alu_codes[i]), alu_exps[i], 32'h1,
           32'h1000 + 32'(4 * i), 5'(i + 1), 1'b1, 1'b0, 2'b00);
      tick();
      if (i > 0) check_m();
    end
    set_nop();
    tick();
    check_m();

    // SUB with immediate operand: 0 - 1 wraps; store data stays RD2
    ALUControlD = 3'b001; ALUSrcD = 1'b1; ImmExtD = 32'h1; RD2D = 32'h55;
    MemWriteD = 1'b1; ResultSrcD = 2'b01; RdD = 5'd6; PCPlus4D = 32'h2004;
    push("subimm", 32'hFFFFFFFF, 32'h55, 32'h2004, 5'd6, 1'b0, 1'b1, 2'b01);
    tick();
    set_nop();
    chk("subimm.rs0e", {31'd0, ResultSrcE0}, 32'h1);
    tick();
    check_m();

    // Forwarding: producer computes 0x100, consumer SUB takes A from M and B from W
    RD1D = 32'h100; RegWriteD = 1'b1; RdD = 5'd4;
    push("fwdprod", 32'h100, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 2'b00);
    tick();
    set_nop();
    ALUControlD = 3'b001; RD1D = 32'h1; RD2D = 32'h2; MemWriteD = 1'b1;
    Rs1D = 5'd4; Rs2D = 5'd5;
    push("fwd", 32'hFFFFFF00, 32'h200, 32'h0, 5'd0, 1'b0, 1'b1, 2'b00);
    tick();
    check_m();
    set_nop();
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h200;
    tick();
    check_m();
    ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = '0;

    // Branch taken (9-9) then not taken (9-8)
    ALUControlD = 3'b001; BranchD = 1'b1; RD1D = 32'd9; RD2D = 32'd9;
    PCD = 32'h40; PCPlus4D = 32'h44; ImmExtD = 32'hFFFFFFF0;
    push("beq_t", 32'h0, 32'd9, 32'h44, 5'd0, 1'b0, 1'b0, 2'b00);
    tick();
    RD2D = 32'd8;
    push("beq_n", 32'h1, 32'd8, 32'h44, 5'd0, 1'b0, 1'b0, 2'b00);
    chk("beq_t.pcsrc",  {31'd0, PCSrcE}, 32'h1);
    chk("beq_t.target", PCTargetE, 32'h30);
    tick();
    set_nop();
    check_m();
    chk("beq_n.pcsrc",  {31'd0, PCSrcE}, 32'h0);
    chk("beq_n.target", PCTargetE, 32'h30);
    tick();
    check_m();

    // Jump
    JumpD = 1'b1; PCD = 32'h100; ImmExtD = 32'h20; PCPlus4D = 32'h104;
    RegWriteD = 1'b1; RdD = 5'd1; ResultSrcD = 2'b10;
    push("jal", 32'h0, 32'h0, 32'h104, 5'd1, 1'b1, 1'b0, 2'b10);
    tick();
    set_nop();
    chk("jal.pcsrc",  {31'd0, PCSrcE}, 32'h1);
    chk("jal.target", PCTargetE, 32'h120);
    tick();
    check_m();

    // Stall: ID/EX holds for three edges while D inputs keep changing
    RD1D = 32'h11; RD2D = 32'h22; Rs1D = 5'd7; Rs2D = 5'd8; RdD = 5'd9; RegWriteD = 1'b1;
    tick();
    chk("stall.rs1e0", {27'd0, Rs1E}, 32'd7);
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      RD1D = $urandom(); RD2D = $urandom(); Rs1D = 5'(20 + i); Rs2D = 5'(24 + i);
      RdD = 5'(28 + i); ALUControlD = 3'b011; JumpD = 1'b1;
      tick();
      chk($sformatf("stall%0d.rs1e", i), {27'd0, Rs1E}, 32'd7);
      chk($sformatf("stall%0d.rs2e", i), {27'd0, Rs2E}, 32'd8);
      chk($sformatf("stall%0d.rde", i),  {27'd0, RdE}, 32'd9);
      chk($sformatf("stall%0d.alu_m", i), ALUResultM, 32'h33);
      chk($sformatf("stall%0d.pcsrc", i), {31'd0, PCSrcE}, 32'h0);
    end

    // Flush together with stall: bubble wins
    FlushE = 1'b1;
    tick();
    chk("flush.rde",   {27'd0, RdE}, 32'd0);
    chk("flush.rs1e",  {27'd0, Rs1E}, 32'd0);
    chk("flush.pcsrc", {31'd0, PCSrcE}, 32'h0);
    chk("flush.rw_m0", {31'd0, RegWriteM}, 32'h1);
    StallE = 1'b0; FlushE = 1'b0;
    set_nop();
    tick();
    chk("flush.rw_m1", {31'd0, RegWriteM}, 32'h0);
    chk("flush.alu_m", ALUResultM, 32'h0);
    chk("flush.rd_m",  {27'd0, RdM}, 32'h0);

    // Reset asserted between clock edges with instructions in flight
    ALUControlD = 3'b000; RD1D = 32'd3; RD2D = 32'd4; JumpD = 1'b1; RegWriteD = 1'b1;
    RdD = 5'd5; PCD = 32'h200; ImmExtD = 32'h8; PCPlus4D = 32'h204;
    tick();
    tick();
    set_nop();
    chk("pre_rst.alu_m", ALUResultM, 32'd7);
    chk("pre_rst.pcsrc", {31'd0, PCSrcE}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.alu_m",  ALUResultM, 32'h0);
    chk("midrst.rw_m",   {31'd0, RegWriteM}, 32'h0);
    chk("midrst.rd_m",   {27'd0, RdM}, 32'h0);
    chk("midrst.pcp4_m", PCPlus4M, 32'h0);
    chk("midrst.rde",    {27'd0, RdE}, 32'h0);
    chk("midrst.pcsrc",  {31'd0, PCSrcE}, 32'h0);
    chk("midrst.target", PCTargetE, 32'h0);
    #2 rst_n = 1'b1;

    RD1D = 32'd5; RD2D = 32'd7; RegWriteD = 1'b1; RdD = 5'd2; PCPlus4D = 32'h8;
    push("add2", 32'd12, 32'd7, 32'h8, 5'd2, 1'b1, 1'b0, 2'b00);
    tick();
    set_nop();
    tick();
    check_m();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage RV32I pipelined core, directly downstream of the ALU control decoder.
- Registers the decode-stage bundle, including the 3-bit ALUControl, into an internal ID/EX register.
- Performs operand forwarding, the ALU operation and branch/jump resolution, then registers the results into an EX/MEM register for the memory stage.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register index width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- StallE  in  1  hold the ID/EX register.
- FlushE  in  1  load a bubble into ID/EX.
- ALUControlD  in  3  ALU op from the ALU control decoder.
- ALUSrcD  in  1  selects B operand: 1=ImmExtD, 0=forwarded RD2.
- RegWriteD, MemWriteD, BranchD, JumpD  in  1 each  decode control bits.
- ResultSrcD  in  2  writeback select, passed through.
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  decode operands.
- Rs1D, Rs2D, RdD  in  REGW each  register indices.
- ForwardAE, ForwardBE  in  2 each  forward select: 00=register, 01=ResultW, 10=ALUResultM; 11 treated as 00.
- ResultW  in  XLEN  writeback-stage result.
- Rs1E, Rs2E, RdE  out  REGW each  ID/EX indices, for the hazard unit.
- ResultSrcE0  out  1  bit 0 of registered ResultSrc, for load-use detection.
- PCSrcE  out  1  redirect fetch.
- PCTargetE  out  XLEN  redirect target.
- RegWriteM, MemWriteM  out  1 each  EX/MEM control.
- ResultSrcM  out  2  EX/MEM writeback select.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN each  EX/MEM data.
- RdM  out  REGW  EX/MEM destination index.

Behaviour:
- Reset (rst_n low, asynchronous): every ID/EX and EX/MEM field clears to 0, so all outputs read 0. PCSrcE=0 because BranchE=JumpE=0. Reset asserted mid-operation discards in-flight instructions immediately, with no wait for a clock edge.
- ID/EX update, per rising edge, in priority order:
  - FlushE=1: clear all fields to 0. Flush wins over stall.
  - else StallE=1: hold all fields.
  - else: capture the D inputs.
- Operand A:
  - ForwardAE 00 or 11: RD1E.
  - 01: ResultW.
  - 10: ALUResultM.
- Forwarded B (the same mux on RD2E) drives the WriteData sent to memory.
- Operand B: ImmExtE if ALUSrcE=1, else forwarded B.
- ALU, combinational on ALUControlE, modulo 2^XLEN, no overflow flag:
  - 000: A+B.
  - 001: A-B.
  - 010: A&B.
  - 011: A|B.
  - 101: signed A<B gives 1, else 0.
  - any other code: 0.
- Zero = (ALU result == 0).
- Branch/jump resolution:
  - PCTargetE = PCE + ImmExtE, modulo 2^XLEN.
  - PCSrcE = (BranchE & Zero) | JumpE. Combinational from ID/EX state, same cycle the instruction is in EX.
- EX/MEM register: captures every rising edge with no stall and no flush input. When StallE=1 the upstream bubble is produced via FlushE of the next stage, so the hazard unit must assert FlushE together with StallE only for a flush.
- Latency: a decode bundle presented before edge k is in EX during cycle k and appears on the M outputs after edge k+1 (2 cycles).
- Boundary cases:
  - A flushed bubble (all zeros) decodes as ADD 0+0 with RegWrite=0 and MemWrite=0, so it has no architectural effect.
  - Sub/add wrap-around: 0x00000000-1 = 0xFFFFFFFF.
  - SLT is signed: 0x80000000 < 0x00000001 yields 1.

Test Plan:
- Reset: drive rst_n low mid-run, between clock edges → all outputs 0 immediately and PCSrcE=0; release, then present ADD RD1=5, RD2=7, ALUSrc=0, RegWrite=1 → after 2 edges ALUResultM=12, RegWriteM=1.
- ALU ops, with A=0x80000000 and B=0x00000001 in turn for each ALUControl → 000: 0x80000001; 001: 0x7FFFFFFF; 010: 0; 011: 0x80000001; 101: 1; 110: 0.
- Forwarding, RD1=1, RD2=2, ALUResultM=0x100, ResultW=0x200, ALU op SUB:
  - ForwardAE=10, ForwardBE=01 → ALU result 0xFFFFFF00.
  - ForwardBE=01 → WriteDataM=0x200 after the next edge.
- Branch: BranchD=1, SUB, RD1=RD2=9, PCD=0x40, ImmExt=0xFFFFFFF0 → in EX, PCSrcE=1 and PCTargetE=0x30; with RD2=8 → PCSrcE=0.
- Jump: JumpD=1, PCD=0x100, Imm=0x20 → PCSrcE=1, PCTargetE=0x120; PCPlus4M equals PCPlus4D one edge after EX.
- Stall/flush:
  - StallE=1 for 3 edges → Rs1E/RdE/ALU result held constant while D inputs change.
  - FlushE=1 together with StallE=1 → RdE=0, RegWriteM=0 one edge later.
